// File: rtl/cuadrado_16.sv
// Sequential shift-add squarer: rebuilds a radicand as R*R + REM, the inverse of the sqrt unit.
// Flags report overflow past N bits and remainders a valid integer square root cannot produce.
module cuadrado_16 #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic [N-1:0] in_R,
   input  logic [N-1:0] in_REM,
   output logic [N-1:0] out_RR,
   output logic         out_OVF,
   output logic         out_INV,
   output logic         out_BUSY,
   output logic         out_DONE
);

   localparam int KW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADDR = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [2*N-1:0] a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   b0_q, b0_d;
   logic [2*N:0]   p_q, p_d;
   logic [N-1:0]   rem_q, rem_d;
   logic [KW-1:0]  k_q, k_d;
   logic [N-1:0]   rr_q, rr_d;
   logic           ovf_q, ovf_d;
   logic           inv_q, inv_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [2*N:0]   sum_s;

   // Next-state and datapath logic for the multiply / remainder-add sequence
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      b0_d    = b0_q;
      p_d     = p_q;
      rem_d   = rem_q;
      k_d     = k_q;
      rr_d    = rr_q;
      ovf_d   = ovf_q;
      inv_d   = inv_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sum_s   = p_q + {{(N+1){1'b0}}, rem_q};
      case (state_q)
         IDLE: begin
            if (init) begin
               a_d     = {{N{1'b0}}, in_R};
               b_d     = in_R;
               b0_d    = in_R;
               p_d     = '0;
               rem_d   = in_REM;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = MUL;
            end else begin
               state_d = IDLE;
            end
         end
         MUL: begin
            p_d    = p_q + (b_q[0] ? {1'b0, a_q} : {(2*N+1){1'b0}});
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            k_d    = k_q + {{(KW-1){1'b0}}, 1'b1};
            busy_d = 1'b1;
            // Fixed N iterations, no early exit, so latency never depends on the operand
            if (k_q == KW'(N-1)) begin
               state_d = ADDR;
            end else begin
               state_d = MUL;
            end
         end
         ADDR: begin
            rr_d    = sum_s[N-1:0];
            ovf_d   = |sum_s[2*N:N];
            inv_d   = {1'b0, rem_q} > {b0_q, 1'b0};
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset that discards any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         b0_q    <= '0;
         p_q     <= '0;
         rem_q   <= '0;
         k_q     <= '0;
         rr_q    <= '0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         b0_q    <= b0_d;
         p_q     <= p_d;
         rem_q   <= rem_d;
         k_q     <= k_d;
         rr_q    <= rr_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_RR   = rr_q;
   assign out_OVF  = ovf_q;
   assign out_INV  = inv_q;
   assign out_BUSY = busy_q;
   assign out_DONE = done_q;

endmodule

// File: tb/tb_cuadrado_16.sv
// Self-checking bench for cuadrado_16: directed vector table, random ops against an
// arithmetic reference, and hand-written handshake / reset sequences.
module tb_cuadrado_16;

   logic        clk;
   logic        rst;
   logic        init;
   logic [15:0] in_R;
   logic [15:0] in_REM;
   logic [15:0] out_RR;
   logic        out_OVF;
   logic        out_INV;
   logic        out_BUSY;
   logic        out_DONE;

   int n_cmp = 0;
   int n_err = 0;

   cuadrado_16 #(.N(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .init     (init),
      .in_R     (in_R),
      .in_REM   (in_REM),
      .out_RR   (out_RR),
      .out_OVF  (out_OVF),
      .out_INV  (out_INV),
      .out_BUSY (out_BUSY),
      .out_DONE (out_DONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic [15:0] rem;
      logic [15:0] exp_rr;
      logic        exp_ovf;
      logic        exp_inv;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic on wide integers
   task automatic model(input logic [15:0] r, input logic [15:0] rem,
                        output logic [15:0] rr, output logic ovf, output logic inv);
      longint full;
      full = longint'(r) * longint'(r) + longint'(rem);
      rr   = full[15:0];
      ovf  = (full > 64'd65535);
      inv  = (longint'(rem) > 2 * longint'(r));
   endtask

   // One complete operation with handshake timing and output-hold checks
   task automatic run_op(input logic [15:0] r, input logic [15:0] rem,
                         input bit mid_init, input bit chg_r,
                         output logic [15:0] rr, output logic ovf, output logic inv);
      int done_cnt;
      int done_edge;
      int busy_bad;
      int hold_bad;
      logic [15:0] rr0;
      logic ovf0;
      logic inv0;
      @(negedge clk);
      in_R   = r;
      in_REM = rem;
      init   = 1'b1;
      rr0    = out_RR;
      ovf0   = out_OVF;
      inv0   = out_INV;
      @(posedge clk);
      #1;
      init      = 1'b0;
      done_cnt  = 0;
      done_edge = -1;
      busy_bad  = (out_BUSY !== 1'b1) ? 1 : 0;
      hold_bad  = 0;
      for (int e = 1; e <= 20; e++) begin
         init = (mid_init && (e == 3 || e == 17)) ? 1'b1 : 1'b0;
         if (chg_r && e == 5) begin
            in_R   = ~r;
            in_REM = ~rem;
         end
         @(posedge clk);
         #1;
         if (out_DONE === 1'b1) begin
            done_cnt++;
            if (done_edge < 0) done_edge = e;
         end
         if (out_BUSY !== ((e <= 16) ? 1'b1 : 1'b0)) busy_bad++;
         if (e <= 16 && (out_RR !== rr0 || out_OVF !== ovf0 || out_INV !== inv0)) hold_bad++;
      end
      init = 1'b0;
      check("done_count", done_cnt, 1);
      check("done_edge", done_edge, 17);
      check("busy_window", busy_bad, 0);
      check("hold_while_busy", hold_bad, 0);
      rr  = out_RR;
      ovf = out_OVF;
      inv = out_INV;
   endtask

   initial begin
      vec_t        vecs[8];
      logic [15:0] rr;
      logic        ovf;
      logic        inv;
      logic [15:0] m_rr;
      logic        m_ovf;
      logic        m_inv;
      logic [15:0] r;
      logic [15:0] rem;
      int          dones[$];
      int          quiet_dones;

      vecs[0] = '{16'd255,   16'd510,   16'd65535, 1'b0, 1'b0};
      vecs[1] = '{16'd255,   16'd0,     16'd65025, 1'b0, 1'b0};
      vecs[2] = '{16'd0,     16'd0,     16'd0,     1'b0, 1'b0};
      vecs[3] = '{16'd1,     16'd2,     16'd3,     1'b0, 1'b0};
      vecs[4] = '{16'd5,     16'd11,    16'd36,    1'b0, 1'b1};
      vecs[5] = '{16'd256,   16'd0,     16'd0,     1'b1, 1'b0};
      vecs[6] = '{16'd65535, 16'd65535, 16'd0,     1'b1, 1'b0};
      vecs[7] = '{16'd12,    16'd3,     16'd147,   1'b0, 1'b0};

      rst    = 1'b1;
      init   = 1'b0;
      in_R   = 16'd0;
      in_REM = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rr", out_RR, 0);
      check("reset_ovf", out_OVF, 0);
      check("reset_inv", out_INV, 0);
      check("reset_busy", out_BUSY, 0);
      check("reset_done", out_DONE, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].r, vecs[i].rem, 1'b0, 1'b0, rr, ovf, inv);
         check($sformatf("vec%0d_rr", i), rr, vecs[i].exp_rr);
         check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
         check($sformatf("vec%0d_inv", i), inv, vecs[i].exp_inv);
      end

      // init re-asserted while busy is ignored
      run_op(16'd200, 16'd7, 1'b1, 1'b0, rr, ovf, inv);
      check("reinit_rr", rr, 16'd40007);
      // operands changing after the start edge have no effect
      run_op(16'd300, 16'd100, 1'b0, 1'b1, rr, ovf, inv);
      check("chg_r_rr", rr, 16'(90100));
      check("chg_r_ovf", ovf, 1);
      check("chg_r_inv", inv, 0);

      for (int i = 0; i < 30; i++) begin
         r   = (i % 2 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         rem = (i % 3 == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
         model(r, rem, m_rr, m_ovf, m_inv);
         run_op(r, rem, 1'b0, 1'b0, rr, ovf, inv);
         check($sformatf("rnd%0d_rr", i), rr, m_rr);
         check($sformatf("rnd%0d_ovf", i), ovf, m_ovf);
         check($sformatf("rnd%0d_inv", i), inv, m_inv);
      end

      // init held high: one operation every N+3 cycles
      @(negedge clk);
      in_R   = 16'd3;
      in_REM = 16'd1;
      init   = 1'b1;
      for (int e = 0; e < 70 && dones.size() < 3; e++) begin
         @(posedge clk);
         #1;
         if (out_DONE === 1'b1) dones.push_back(e);
      end
      init = 1'b0;
      check("held_done_count", dones.size(), 3);
      if (dones.size() == 3) begin
         check("held_first", dones[0], 17);
         check("held_gap1", dones[1] - dones[0], 19);
         check("held_gap2", dones[2] - dones[1], 19);
      end
      check("held_rr", out_RR, 16'd10);
      repeat (25) @(posedge clk);

      // reset in the middle of MUL discards the operation
      @(negedge clk);
      in_R   = 16'd100;
      in_REM = 16'd0;
      init   = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rr", out_RR, 0);
      check("midrst_ovf", out_OVF, 0);
      check("midrst_inv", out_INV, 0);
      check("midrst_busy", out_BUSY, 0);
      check("midrst_done", out_DONE, 0);
      rst = 1'b0;
      quiet_dones = 0;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk);
         #1;
         if (out_DONE === 1'b1 || out_BUSY === 1'b1) quiet_dones++;
      end
      check("midrst_no_activity", quiet_dones, 0);
      run_op(16'd12, 16'd3, 1'b0, 1'b0, rr, ovf, inv);
      check("after_rst_rr", rr, 16'd147);
      check("after_rst_ovf", ovf, 0);
      check("after_rst_inv", inv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cuadrado_16.md
Name: cuadrado_16

Overview:
- Sequential shift-add squarer that rebuilds a radicand from a root and remainder: out_RR = in_R*in_R + in_REM.
- It is the inverse of the team's 16-bit integer square-root unit and uses the same init/out_DONE handshake, so it can sit downstream of it in a loopback checker.
- A small FSM sequences the multiply and the remainder add.
- Flags report results that overflow 16 bits and remainders that cannot come from a valid integer square root.

Parameters:
- N, 16, operand and result width. The iteration count equals N.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- init  input  1  start request, sampled only in IDLE
- in_R  input  N  root operand, captured on the start edge
- in_REM  input  N  remainder operand, captured on the start edge
- out_RR  output  N  low N bits of R*R+REM, held between operations
- out_OVF  output  1  1 when the full R*R+REM exceeds 2^N-1
- out_INV  output  1  1 when REM > 2*R (not a valid sqrt remainder)
- out_BUSY  output  1  1 in states MUL and ADDR
- out_DONE  output  1  single-cycle completion pulse

Behaviour:
- Reset: on any edge with rst=1, state=IDLE and out_RR=0, out_OVF=0, out_INV=0, out_BUSY=0, out_DONE=0. Internal A, B, P and K are cleared. Reset overrides every other input, including mid-operation; the aborted result is discarded.
- Datapath:
  - A: 2N-bit multiplicand, shifted left each iteration.
  - B: N-bit multiplier, shifted right each iteration.
  - P: 2N+1-bit accumulator.
  - REMr: captured remainder.
  - K: iteration counter of width clog2(N)+1.
- IDLE: if init=1, then A={0,in_R}, B=in_R, P=0, REMr=in_REM, K=0, and the next state is MUL. Otherwise stay in IDLE.
- MUL (exactly N cycles): each edge does P=P+(B[0]?A:0), A=A<<1, B=B>>1, K=K+1. When K==N-1 on the edge, the next state is ADDR. There is no early termination, so latency is fixed.
- ADDR (1 cycle): the edge computes S=P+REMr and registers:
  - out_RR=S[N-1:0]
  - out_OVF=(S>2^N-1)
  - out_INV=(REMr>2*B0), where B0 is the captured root, kept in a copy register and compared at N+1 bits.
  - The next state is DONE.
- DONE (1 cycle): out_DONE=1 and out_BUSY=0. The next state is IDLE unconditionally.
- Latency: init is sampled on edge 0 and out_DONE is high during the cycle after edge N+1 (cycle 17 for N=16). The next start is accepted no earlier than edge N+3.
- init is ignored in MUL, ADDR and DONE; there is no queuing. init held high continuously restarts on every IDLE visit, giving one operation per N+3 cycles.
- out_RR, out_OVF and out_INV change only on the ADDR edge or on reset. They stay stable while busy and afterwards, until the next ADDR edge.
- in_R and in_REM may change freely after the start edge without affecting the result.
- Arithmetic is unsigned throughout. The 2N+1-bit P plus REM cannot wrap internally.

Test Plan:
- Valid maximum: rst then in_R=255, in_REM=510, init pulse -> out_DONE pulses exactly once, 17 cycles after the init edge; out_RR=65535, out_OVF=0, out_INV=0; out_BUSY high for cycles 1-16.
- Perfect squares: R=255, REM=0 gives 65025. R=0, REM=0 gives 0 with flags 0. R=1, REM=2 gives 3 with INV=0.
- Invalid remainder: R=5, REM=11 -> out_RR=36, out_INV=1, out_OVF=0.
- Overflow: R=256, REM=0 -> out_RR=0, out_OVF=1. R=65535, REM=65535 -> out_RR=0x0000, out_OVF=1, out_INV=0.
- Handshake:
  - Re-assert init at cycles 3 and 17 during an operation -> both ignored; exactly one out_DONE.
  - init held high permanently -> a DONE pulse every 19 cycles.
  - Change in_R mid-operation -> no effect on the result.
- Reset mid-operation: assert rst at MUL cycle 8 -> next cycle all outputs are 0 and state is IDLE, with no out_DONE. A fresh R=12, REM=3 then gives 147.
